// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : Pipelined RV32I/RV64I immediate generator (I/S/B/U/J/zimm) with
//            OP-IMM shift-amount masking, unknown-opcode flag, and a
//            valid/ready handshake backed by a main + skid register pair.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 8,
  parameter int SHAMT_MASK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_code,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt,
  output logic             imm_err,
  output logic [TAG_W-1:0] out_tag
);

  // Major opcodes (inst[6:0])
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_system = 7'b1110011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;

  // Format codes reported on fmt
  localparam logic [2:0] c_fmt_none = 3'd0;
  localparam logic [2:0] c_fmt_i    = 3'd1;
  localparam logic [2:0] c_fmt_s    = 3'd2;
  localparam logic [2:0] c_fmt_b    = 3'd3;
  localparam logic [2:0] c_fmt_u    = 3'd4;
  localparam logic [2:0] c_fmt_j    = 3'd5;
  localparam logic [2:0] c_fmt_z    = 3'd6;

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_dec_err;
  logic            w_in_fire;

  // Main (M) and skid (K) registers; M always holds the oldest word
  logic             r_m_full;
  logic [XLEN-1:0]  r_m_imm;
  logic [2:0]       r_m_fmt;
  logic             r_m_err;
  logic [TAG_W-1:0] r_m_tag;
  logic             r_k_full;
  logic [XLEN-1:0]  r_k_imm;
  logic [2:0]       r_k_fmt;
  logic             r_k_err;
  logic [TAG_W-1:0] r_k_tag;

  assign w_op    = inst_code[6:0];
  assign w_f3    = inst_code[14:12];
  assign w_imm_i = XLEN'($signed(inst_code[31:20]));

  // RV64 shifts carry a 6-bit shamt, RV32 only 5 bits
  generate
    if (XLEN == 64) begin : g_shamt64
      assign w_shamt = XLEN'(inst_code[25:20]);
    end else begin : g_shamt32
      assign w_shamt = XLEN'(inst_code[24:20]);
    end
  endgenerate

  // Combinational immediate decode keyed on the major opcode
  always_comb begin
    w_dec_imm = '0;
    w_dec_fmt = c_fmt_none;
    w_dec_err = 1'b0;
    case (w_op)
      c_op_load, c_op_jalr: begin
        w_dec_imm = w_imm_i;
        w_dec_fmt = c_fmt_i;
      end
      c_op_imm: begin
        w_dec_fmt = c_fmt_i;
        // SLLI (001) / SRLI,SRAI (101): upper imm bits are funct7, not value
        if ((SHAMT_MASK != 0) && ((w_f3 == 3'b001) || (w_f3 == 3'b101)))
          w_dec_imm = w_shamt;
        else
          w_dec_imm = w_imm_i;
      end
      c_op_store: begin
        w_dec_imm = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
        w_dec_fmt = c_fmt_s;
      end
      c_op_branch: begin
        w_dec_imm = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                   inst_code[11:8], 1'b0}));
        w_dec_fmt = c_fmt_b;
      end
      c_op_lui, c_op_auipc: begin
        w_dec_imm = XLEN'($signed({inst_code[31:12], 12'b0}));
        w_dec_fmt = c_fmt_u;
      end
      c_op_jal: begin
        w_dec_imm = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                   inst_code[30:21], 1'b0}));
        w_dec_fmt = c_fmt_j;
      end
      c_op_system: begin
        // Only the immediate CSR forms (funct3[2]=1) carry a zimm
        if (inst_code[14]) begin
          w_dec_imm = XLEN'(inst_code[19:15]);
          w_dec_fmt = c_fmt_z;
        end
      end
      c_op_reg: begin
        w_dec_fmt = c_fmt_none;
      end
      default: begin
        w_dec_err = 1'b1;
      end
    endcase
  end

  // in_ready depends only on skid occupancy, so no combinational ready path
  assign in_ready  = ~r_k_full;
  assign w_in_fire = in_valid & ~r_k_full;
  assign out_valid = r_m_full;
  assign imm_out   = r_m_imm;
  assign fmt       = r_m_fmt;
  assign imm_err   = r_m_err;
  assign out_tag   = r_m_tag;

  // Occupancy (EMPTY/ONE/TWO) and data movement through M and K
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_full <= 1'b0;
      r_m_imm  <= '0;
      r_m_fmt  <= c_fmt_none;
      r_m_err  <= 1'b0;
      r_m_tag  <= '0;
      r_k_full <= 1'b0;
      r_k_imm  <= '0;
      r_k_fmt  <= c_fmt_none;
      r_k_err  <= 1'b0;
      r_k_tag  <= '0;
    end else if (r_k_full) begin
      // TWO: no input accepted; drain K into M when M is consumed
      if (out_ready) begin
        r_m_imm  <= r_k_imm;
        r_m_fmt  <= r_k_fmt;
        r_m_err  <= r_k_err;
        r_m_tag  <= r_k_tag;
        r_k_full <= 1'b0;
      end
    end else if (r_m_full) begin
      // ONE: reload M on pass-through, park in K under a stall
      if (w_in_fire) begin
        if (out_ready) begin
          r_m_imm <= w_dec_imm;
          r_m_fmt <= w_dec_fmt;
          r_m_err <= w_dec_err;
          r_m_tag <= in_tag;
        end else begin
          r_k_imm  <= w_dec_imm;
          r_k_fmt  <= w_dec_fmt;
          r_k_err  <= w_dec_err;
          r_k_tag  <= in_tag;
          r_k_full <= 1'b1;
        end
      end else if (out_ready) begin
        r_m_full <= 1'b0;
      end
    end else if (w_in_fire) begin
      // EMPTY: first word goes straight into M
      r_m_imm  <= w_dec_imm;
      r_m_fmt  <= w_dec_fmt;
      r_m_err  <= w_dec_err;
      r_m_tag  <= in_tag;
      r_m_full <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Self-checking bench for imm_gen_pipe. Three instances (RV32 with
//            shamt masking, RV64 with masking, RV32 without) share one input
//            stream; a depth-2 FIFO model plus an arithmetic decode reference
//            predict every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [31:0] inst;
    logic [7:0]  tag;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst_code;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        ir32, ov32, err32, ir64, ov64, err64, irn, ovn, errn;
  logic [31:0] imm32, immn;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64, fmtn;
  logic [7:0]  tag32, tag64, tagn;

  logic        o_ir  [3];
  logic        o_ov  [3];
  logic [63:0] o_imm [3];
  logic [2:0]  o_fmt [3];
  logic        o_err [3];
  logic [7:0]  o_tag [3];

  word_t q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SHAMT_MASK(1)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
    .inst_code(inst_code), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .imm_out(imm32), .fmt(fmt32), .imm_err(err32), .out_tag(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SHAMT_MASK(1)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
    .inst_code(inst_code), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .imm_out(imm64), .fmt(fmt64), .imm_err(err64), .out_tag(tag64));

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SHAMT_MASK(0)) u_d32n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irn),
    .inst_code(inst_code), .in_tag(in_tag), .out_valid(ovn), .out_ready(out_ready),
    .imm_out(immn), .fmt(fmtn), .imm_err(errn), .out_tag(tagn));

  assign o_ir[0]  = ir32;          assign o_ir[1]  = ir64;   assign o_ir[2]  = irn;
  assign o_ov[0]  = ov32;          assign o_ov[1]  = ov64;   assign o_ov[2]  = ovn;
  assign o_imm[0] = {32'b0, imm32}; assign o_imm[1] = imm64; assign o_imm[2] = {32'b0, immn};
  assign o_fmt[0] = fmt32;         assign o_fmt[1] = fmt64;  assign o_fmt[2] = fmtn;
  assign o_err[0] = err32;         assign o_err[1] = err64;  assign o_err[2] = errn;
  assign o_tag[0] = tag32;         assign o_tag[1] = tag64;  assign o_tag[2] = tagn;

  // ---------------- reference decode ----------------
  function automatic logic [2:0] ref_fmt(logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67: return 3'd1;
      7'h23:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h6F:               return 3'd5;
      7'h73:               return w[14] ? 3'd6 : 3'd0;
      default:             return 3'd0;
    endcase
  endfunction

  function automatic logic ref_err(logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(logic [31:0] w, bit x64, bit msk);
    longint v;
    logic [63:0] r;
    v = 0;
    case (w[6:0])
      7'h03, 7'h67: v = longint'($signed(w[31:20]));
      7'h13: begin
        if (msk && (w[14:12] == 3'd1 || w[14:12] == 3'd5))
          v = x64 ? longint'(w[25:20]) : longint'(w[24:20]);
        else
          v = longint'($signed(w[31:20]));
      end
      7'h23: v = longint'($signed({w[31:25], w[11:7]}));
      7'h63: v = 2 * longint'($signed({w[31], w[7], w[30:25], w[11:8]}));
      7'h37, 7'h17: v = 4096 * longint'($signed(w[31:12]));
      7'h6F: v = 2 * longint'($signed({w[31], w[19:12], w[20], w[30:21]}));
      7'h73: v = w[14] ? longint'(w[19:15]) : 0;
      default: v = 0;
    endcase
    r = v;
    if (!x64) r[63:32] = 32'b0;
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10];
    logic [31:0] r;
    int k;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) r[6:0] = ops[k];
    return r;
  endfunction

  // One clock: update the FIFO model from pre-edge handshake state
  task automatic tick(output bit acc);
    bit    fo, fi;
    word_t w;
    @(posedge clk);
    fo = (q.size() > 0) && (out_ready === 1'b1);
    fi = (in_valid === 1'b1) && (q.size() < 2);
    if (fo) void'(q.pop_front());
    if (fi) begin
      w.inst = inst_code;
      w.tag  = in_tag;
      q.push_back(w);
    end
    acc = fi;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; inst_code = '0; in_tag = '0; out_ready = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_ov[k], o_imm[k], o_fmt[k], o_err[k], o_tag[k]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs[%0d] got ov=%b imm=%h fmt=%0d err=%b tag=%h exp all zero",
                 k, o_ov[k], o_imm[k], o_fmt[k], o_err[k], o_tag[k]);
      end
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick(acc);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_ir[k], o_ov[k]} !== 2'b10) begin
        failures++;
        $display("FAIL reset_release[%0d] got ir=%b ov=%b exp ir=1 ov=0", k, o_ir[k], o_ov[k]);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] t_inst [12];
    logic [31:0] t_e32  [12];
    logic [63:0] t_e64  [12];
    logic [2:0]  t_fmt  [12];
    logic        t_err  [12];
    bit acc;
    t_inst = '{32'hFFF00093, 32'hFE112E23, 32'h00000863, 32'h123452B7, 32'hFF9FF06F,
               32'h41F0D093, 32'h3002D073, 32'h0000007F, 32'h800002B7, 32'h03F09093,
               32'h00000033, 32'h30001073};
    t_e32  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h10, 32'h12345000, 32'hFFFFFFF8,
               32'h1F, 32'h5, 32'h0, 32'h80000000, 32'h1F, 32'h0, 32'h0};
    t_e64  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h10, 64'h12345000,
               64'hFFFFFFFFFFFFFFF8, 64'h1F, 64'h5, 64'h0, 64'hFFFFFFFF80000000,
               64'h3F, 64'h0, 64'h0};
    t_fmt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd6, 3'd0, 3'd4, 3'd1, 3'd0, 3'd0};
    t_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      inst_code = t_inst[i];
      in_tag    = 8'(i + 3);
      tick(acc);
      checks++;
      if ({acc, ov32, ir32, imm32, fmt32, err32, tag32} !==
          {1'b1, 1'b1, 1'b1, t_e32[i], t_fmt[i], t_err[i], 8'(i + 3)}) begin
        failures++;
        $display("FAIL directed32[%0d] inst=%h got acc=%b ov=%b ir=%b imm=%h fmt=%0d err=%b tag=%h exp imm=%h fmt=%0d err=%b tag=%h",
                 i, t_inst[i], acc, ov32, ir32, imm32, fmt32, err32, tag32,
                 t_e32[i], t_fmt[i], t_err[i], 8'(i + 3));
      end
      checks++;
      if ({ov64, imm64, fmt64, err64, tag64} !== {1'b1, t_e64[i], t_fmt[i], t_err[i], 8'(i + 3)}) begin
        failures++;
        $display("FAIL directed64[%0d] inst=%h got ov=%b imm=%h fmt=%0d err=%b tag=%h exp imm=%h",
                 i, t_inst[i], ov64, imm64, fmt64, err64, tag64, t_e64[i]);
      end
    end
    in_valid = 1'b0;
    inst_code = 'x;
    tick(acc);
    checks++;
    if ({ov32, ov64, ovn} !== 3'b000 || $isunknown({imm32, imm64, immn, fmt32, tag32})) begin
      failures++;
      $display("FAIL drain_idle got ov=%b%b%b imm32=%h exp ov=000 and known outputs",
               ov32, ov64, ovn, imm32);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    logic [7:0]  seen [$];
    logic [63:0] e_imm;
    bit acc;
    int n;
    w = '{32'hFFF00093, 32'hFE112E23, 32'h00000863};
    out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 24 && !(n == 3 && q.size() == 0); c++) begin
      if (c == 6) out_ready = 1'b1;
      if (n < 3) begin
        in_valid = 1'b1; inst_code = w[n]; in_tag = 8'hA0 + 8'(n);
      end else begin
        in_valid = 1'b0; inst_code = 'x; in_tag = 'x;
      end
      if (ov32 === 1'b1 && out_ready === 1'b1) seen.push_back(tag32);
      tick(acc);
      if (acc) n++;
      if (c >= 2 && c < 6) begin
        checks++;
        if ({ir32, ov32, imm32, tag32} !== {1'b0, 1'b1, 32'hFFFFFFFF, 8'hA0}) begin
          failures++;
          $display("FAIL stall_frozen c=%0d got ir=%b ov=%b imm=%h tag=%h exp ir=0 ov=1 imm=ffffffff tag=a0",
                   c, ir32, ov32, imm32, tag32);
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({o_ir[k], o_ov[k]} !== {q.size() < 2, q.size() > 0}) begin
          failures++;
          $display("FAIL bp_flags[%0d] c=%0d got ir=%b ov=%b exp ir=%b ov=%b",
                   k, c, o_ir[k], o_ov[k], q.size() < 2, q.size() > 0);
        end
        if (q.size() > 0) begin
          e_imm = ref_imm(q[0].inst, k == 1, k != 2);
          checks++;
          if ({o_imm[k], o_fmt[k], o_err[k], o_tag[k]} !==
              {e_imm, ref_fmt(q[0].inst), ref_err(q[0].inst), q[0].tag}) begin
            failures++;
            $display("FAIL bp_data[%0d] c=%0d got imm=%h fmt=%0d tag=%h exp imm=%h fmt=%0d tag=%h",
                     k, c, o_imm[k], o_fmt[k], o_tag[k], e_imm, ref_fmt(q[0].inst), q[0].tag);
          end
        end
      end
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 8'hA0 || seen[1] !== 8'hA1 || seen[2] !== 8'hA2) begin
      failures++;
      $display("FAIL bp_order got %0d words first=%h exp 3 words a0,a1,a2",
               seen.size(), (seen.size() > 0) ? seen[0] : 8'h00);
    end
  endtask

  task automatic test_random();
    logic [63:0] e_imm;
    bit acc;
    acc = 1'b1;
    for (int c = 0; c < 600; c++) begin
      // Producer must hold a word that was offered but not taken
      if (!(in_valid === 1'b1 && !acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) begin
          inst_code = rand_inst();
          in_tag    = 8'($urandom);
        end else begin
          inst_code = 'x;
          in_tag    = 'x;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({o_ir[k], o_ov[k]} !== {q.size() < 2, q.size() > 0}) begin
          failures++;
          $display("FAIL rnd_flags[%0d] c=%0d got ir=%b ov=%b exp ir=%b ov=%b",
                   k, c, o_ir[k], o_ov[k], q.size() < 2, q.size() > 0);
        end
        if (q.size() > 0) begin
          e_imm = ref_imm(q[0].inst, k == 1, k != 2);
          checks++;
          if ({o_imm[k], o_fmt[k], o_err[k], o_tag[k]} !==
              {e_imm, ref_fmt(q[0].inst), ref_err(q[0].inst), q[0].tag}) begin
            failures++;
            $display("FAIL rnd_data[%0d] c=%0d inst=%h got imm=%h fmt=%0d err=%b tag=%h exp imm=%h fmt=%0d err=%b tag=%h",
                     k, c, q[0].inst, o_imm[k], o_fmt[k], o_err[k], o_tag[k],
                     e_imm, ref_fmt(q[0].inst), ref_err(q[0].inst), q[0].tag);
          end
        end else begin
          checks++;
          if ($isunknown({o_imm[k], o_fmt[k], o_err[k], o_tag[k]})) begin
            failures++;
            $display("FAIL rnd_xprop[%0d] c=%0d got imm=%h fmt=%b exp known values",
                     k, c, o_imm[k], o_fmt[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit acc;
    in_valid = 1'b0; inst_code = '0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick(acc);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; inst_code = 32'h123452B7; in_tag = 8'h50 + 8'(i);
      tick(acc);
    end
    checks++;
    if ({ov32, ir32, ov64, ir64} !== 4'b1010) begin
      failures++;
      $display("FAIL pre_reset_full got ov32=%b ir32=%b ov64=%b ir64=%b exp 1 0 1 0",
               ov32, ir32, ov64, ir64);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_ov[k], o_imm[k], o_fmt[k], o_err[k], o_tag[k]} !== '0) begin
        failures++;
        $display("FAIL async_reset[%0d] got ov=%b imm=%h fmt=%0d err=%b tag=%h exp all zero",
                 k, o_ov[k], o_imm[k], o_fmt[k], o_err[k], o_tag[k]);
      end
    end
    q.delete();
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0; inst_code = 'x; in_tag = 'x; out_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(acc);
      checks++;
      if ({ir32, ov32, ir64, ov64, irn, ovn} !== 6'b101010) begin
        failures++;
        $display("FAIL post_reset_idle c=%0d got ir/ov=%b%b %b%b %b%b exp 10 10 10",
                 c, ir32, ov32, ir64, ov64, irn, ovn);
      end
    end
    in_valid = 1'b1; inst_code = 32'h0000007F; in_tag = 8'h77;
    tick(acc);
    in_valid = 1'b0; inst_code = 'x;
    checks++;
    if ({ov32, imm32, fmt32, err32, tag32} !== {1'b1, 32'h0, 3'd0, 1'b1, 8'h77}) begin
      failures++;
      $display("FAIL post_reset_word got ov=%b imm=%h fmt=%0d err=%b tag=%h exp ov=1 imm=0 fmt=0 err=1 tag=77",
               ov32, imm32, fmt32, err32, tag32);
    end
    tick(acc);
    checks++;
    if (ov32 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_dup got ov=%b exp 0", ov32);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
